log2_rr_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit floor-log2 (highest-set-bit) encoder among `N_REQ` requesters. Each requester presents an 8-bit operand with a valid/ready handshake. The block grants one requester per cycle, registers the encoded result together with the requester index, and presents it on a single valid/ready response port. It sits between the requesting datapath clients and downstream consumers of exponent values.

---
 rtl/log2_rr_sched.sv | 120 ++++++++++++
 tb/tb_log2_rr_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/log2_rr_sched.sv
// log2_rr_sched: round-robin scheduler sharing one 8-bit floor-log2 encoder
// among N_REQ requesters, with a single registered valid/ready response port.
module log2_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_pow,
  output logic                 rsp_zero,
  output logic [ID_W-1:0]      rsp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]      pow_q, pow_d;
  logic            zero_q, zero_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            can_accept;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic [7:0]      grant_data;
  logic [2:0]      enc_pow;
  logic            enc_zero;

  assign rsp_valid  = (state_q == FULL);
  assign rsp_pow    = pow_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;

  // The result register can take a new operand when empty or being drained.
  assign can_accept = !rst && (!rsp_valid || rsp_ready);
  assign grant      = can_accept && found;

  // Scan requesters starting at rr_ptr; index arithmetic wraps naturally
  // because N_REQ is a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = rr_ptr_q + ID_W'(k);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // One-hot acknowledge to the granted requester, independent of req_data.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_data = req_data[8*grant_idx +: 8];

  // Highest-set-bit encoder over all 8 bits; later (higher) bits win.
  always_comb begin
    enc_pow  = 3'd0;
    enc_zero = (grant_data == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (grant_data[i]) begin
        enc_pow = 3'(i);
      end
    end
  end

  // Output FSM next state, result reload and priority pointer advance.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    pow_d    = pow_q;
    zero_d   = zero_q;
    id_d     = id_q;
    case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (rsp_ready && !grant) state_d = EMPTY;
    endcase
    if (grant) begin
      pow_d    = enc_pow;
      zero_d   = enc_zero;
      id_d     = grant_idx;
      rr_ptr_d = grant_idx + ID_W'(1);
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      pow_q    <= 3'd0;
      zero_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      pow_q    <= pow_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
    end
  end

endmodule

// File: tb/tb_log2_rr_sched.sv
// Testbench for log2_rr_sched: directed steps followed by random traffic,
// each cycle compared against a behavioural scheduler model.
module tb_log2_rr_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2:0]     rsp_pow;
  logic           rsp_zero;
  logic [IDW-1:0] rsp_id;

  int vectors     = 0;
  int miscompares = 0;

  int m_valid;
  int m_pow;
  int m_zero;
  int m_id;
  int m_ptr;
  int last_grant;

  logic [N-1:0]   pend_v;
  logic [8*N-1:0] pend_d;
  logic [7:0]     enc_list [5];

  log2_rr_sched #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pow   (rsp_pow),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_log2(input int v);
    int p;
    p = 0;
    while (v > 1) begin
      v = v / 2;
      p++;
    end
    return p;
  endfunction

  function automatic int model_grant(input logic r, input logic [N-1:0] v, input logic rr);
    int i;
    if (r || (m_valid != 0 && !rr)) return -1;
    for (int off = 0; off < N; off++) begin
      i = (m_ptr + off) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [8*N-1:0] d, input logic rr);
    int g;
    int b;
    int exp_ready;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    g          = model_grant(r, v, rr);
    last_grant = g;
    exp_ready  = (g < 0) ? 0 : (1 << g);
    checkOutput("req_ready", 32'(req_ready), exp_ready);
    @(posedge clk);
    if (r) begin
      m_valid = 0;
      m_pow   = 0;
      m_zero  = 0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      b       = int'(d[8*g +: 8]);
      m_valid = 1;
      m_pow   = ref_log2(b);
      m_zero  = (b == 0) ? 1 : 0;
      m_id    = g;
      m_ptr   = (g + 1) % N;
    end else if (m_valid != 0 && rr) begin
      m_valid = 0;
    end
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid), m_valid);
    checkOutput("rsp_pow",   32'(rsp_pow),   m_pow);
    checkOutput("rsp_zero",  32'(rsp_zero),  m_zero);
    checkOutput("rsp_id",    32'(rsp_id),    m_id);
  endtask

  // Directed sequence followed by protocol-respecting random traffic.
  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    m_valid    = 0;
    m_pow      = 0;
    m_zero     = 0;
    m_id       = 0;
    m_ptr      = 0;
    last_grant = -1;
    pend_v     = '0;
    pend_d     = '0;
    enc_list   = '{8'h00, 8'h01, 8'h03, 8'h5A, 8'hFF};

    $display("[TB] reset with all requesters valid");
    repeat (2) applyStimulus(1'b1, '1, 32'hA5C3_0F81, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);

    $display("[TB] single requester 1 sends 0x80");
    applyStimulus(1'b0, 4'b0010, 32'h0000_8000, 1'b1);

    $display("[TB] encoding sweep through requester 0");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0001, {24'h0, enc_list[i]}, 1'b1);
    end
    for (int v = 0; v < 256; v++) begin
      applyStimulus(1'b0, 4'b0001, {24'h0, 8'(v)}, 1'b1);
    end

    $display("[TB] fairness, all requesters valid");
    applyStimulus(1'b0, 4'b1000, 32'h1100_0000, 1'b1);
    repeat (8) applyStimulus(1'b0, '1, $urandom, 1'b1);

    $display("[TB] fairness, requesters 1 and 3");
    repeat (6) applyStimulus(1'b0, 4'b1010, $urandom, 1'b1);

    $display("[TB] backpressure");
    repeat (3) applyStimulus(1'b0, '1, $urandom, 1'b0);
    applyStimulus(1'b0, '1, $urandom, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 4'b0010, $urandom, 1'b1);
    applyStimulus(1'b1, '1, $urandom, 1'b1);
    applyStimulus(1'b0, '1, $urandom, 1'b1);

    $display("[TB] random traffic");
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend_v[i]         = 1'b1;
          pend_d[8*i +: 8]  = 8'($urandom >> $urandom_range(0, 7));
        end
      end
      applyStimulus(($urandom_range(0, 63) == 0), pend_v, pend_d, ($urandom_range(0, 3) != 0));
      if (last_grant >= 0) pend_v[last_grant] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
